sprite_compositor: RTL and testbench
====================================

// Module: sprite_compositor
// PURPOSE
//  Parametrised per-pixel colour generator for the 640x480 VGA path. Holds a table of
//  NUM_SPRITES sprites (position, radius, shape, colour, enable) and, for each pixel
//  coordinate the VGA timing block announces, returns the colour of the highest-priority
//  sprite covering it, or BG_COLOR. Sits between game logic (writes the table) and the VGA
//  output driver. Table updates are double-buffered and committed only at frame start,
//  so a frame never shows a torn sprite.
// PARAMETERS
//  NUM_SPRITES  8      sprite slots; slot 0 has the highest priority
//  COORD_W      10     pixel and sprite coordinate width, unsigned
//  RADIUS_W     7      sprite half-size / radius width, unsigned
//  COLOR_W      8      colour width (RGB332 at default)
//  BG_COLOR     8'h00  colour driven when no sprite hits, and during clear
// PORTS
//  clk        in   1                  system clock
//  rst        in   1                  asynchronous reset, active-high
//  start      in   1                  1 = run; 0 = force IDLE, output BG_COLOR
//  pix_valid  in   1                  next_x/next_y hold a valid pixel this cycle
//  next_x     in   COORD_W            coordinate of the next pixel to be drawn
//  next_y     in   COORD_W            coordinate of the next pixel to be drawn
//  wr_en      in   1                  write one shadow table entry
//  wr_idx     in   clog2(NUM_SPRITES) slot written
//  wr_x       in   COORD_W            sprite centre x
//  wr_y       in   COORD_W            sprite centre y
//  wr_radius  in   RADIUS_W           half-size (box/ring) or radius (disc)
//  wr_shape   in   2                  0 box, 1 ring, 2 disc, 3 hidden
//  wr_color   in   COLOR_W            sprite colour
//  color_out  out  COLOR_W            pixel colour, 3-cycle latency
//  color_vld  out  1                  color_out corresponds to a valid pixel
//  hit_mask   out  NUM_SPRITES        all sprites covering that pixel (before priority)
//  collide    out  1                  sticky per frame: slot 0 overlapped any other slot
// BEHAVIOUR
//  Reset: color_out=BG_COLOR, color_vld=0, hit_mask=0, collide=0, FSM=IDLE;
//   active and shadow tables all shape=3 (hidden).
//  Frame boundary (fb) = pix_valid && next_x==0 && next_y==0.
//  FSM: IDLE -(start=1)-> CLEAR -(fb)-> RUN; start=0 in any state -> IDLE next cycle.
//   IDLE: color_vld=0, color_out=BG_COLOR, pipeline flushed.
//   CLEAR: pipeline runs; color_out forced BG_COLOR and hit_mask=0 (first frame is blank).
//   RUN: normal compositing.
//  Table: wr_en writes shadow[wr_idx] the next cycle; an out-of-range wr_idx is ignored.
//   On fb, shadow is copied into active in the same cycle; that pixel and every later pixel
//   use the new table. wr_en coincident with fb: the write lands in shadow and is committed
//   at the next fb (the copy takes the pre-write shadow).
//  Pipeline (advances every cycle; valid bit travels with the data):
//   S1 dx=$signed({1'b0,next_x})-$signed({1'b0,sx}), same for dy (COORD_W+1 bits); |dx|,|dy|.
//   S2 hit: box  |dx|<=r && |dy|<=r; ring max(|dx|,|dy|)==r; disc dx*dx+dy*dy<=r*r
//      (2*COORD_W+2 bits, no truncation); hidden never hits.
//   S3 color_out = colour of the lowest-index hit slot, else BG_COLOR; hit_mask registered.
//   Latency: pixel at cycle t -> color_out/color_vld at t+3. pix_valid=0 bubbles propagate
//   as color_vld=0, and color_out holds its last value.
//  No coordinate wrap: differences are signed, so sprites near 0 or the max coordinate clip
//   correctly. r=0 box/disc covers only the centre pixel; r=0 ring covers only the centre.
//  collide: set when an S3 pixel has hit_mask[0] and any other bit set; cleared when fb
//   enters S3, unless that pixel itself collides (set wins).
//  start deasserted mid-frame: pipeline and collide cleared; tables are retained.
// TESTING
//  1 rst, start=1, slot0 box @(100,100) r=10 colour E0, scan one frame -> all BG; 2nd frame
//    E0 exactly on x,y in [90,110], color_vld 3 cycles after pix_valid.
//  2 slot0 disc r=5 @(50,50): (53,54) -> hit (25<=25); (54,54) -> BG (32>25).
//  3 slot0 ring r=4 @(20,20) and slot1 box r=8 @(20,20) colour 1C: (24,20) -> slot0 colour;
//    (21,20) -> 1C; hit_mask at (24,20) = 2'b11; collide=1 by end of frame.
//  4 write slot2 mid-frame -> no change until next fb; write on the fb cycle -> appears one
//    frame later.
//  5 box r=5 @(2,2): (0,0) hit, (639,0) no hit (no wrap); wr_idx=NUM_SPRITES ignored.
//  6 drop start mid-frame -> color_vld=0 next cycle, collide=0; reassert -> blank clear frame.

Source files
------------

// File: rtl/sprite_compositor.sv
// sprite_compositor: per-pixel sprite compositing with a double-buffered sprite table
module sprite_compositor #(
  parameter int NUM_SPRITES = 8,
  parameter int COORD_W = 10,
  parameter int RADIUS_W = 7,
  parameter int COLOR_W = 8,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0,
  localparam int IW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pix_valid,
  input  logic [COORD_W-1:0]     next_x,
  input  logic [COORD_W-1:0]     next_y,
  input  logic                   wr_en,
  input  logic [IW-1:0]          wr_idx,
  input  logic [COORD_W-1:0]     wr_x,
  input  logic [COORD_W-1:0]     wr_y,
  input  logic [RADIUS_W-1:0]    wr_radius,
  input  logic [1:0]             wr_shape,
  input  logic [COLOR_W-1:0]     wr_color,
  output logic [COLOR_W-1:0]     color_out,
  output logic                   color_vld,
  output logic [NUM_SPRITES-1:0] hit_mask,
  output logic                   collide
);
  localparam int SW = 2*COORD_W+2;
  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [RADIUS_W-1:0] r;
    logic [1:0]          shape;
    logic [COLOR_W-1:0]  color;
  } spr_t;
  localparam spr_t HIDDEN = spr_t'({(2*COORD_W+RADIUS_W)'(0), 2'd3, COLOR_W'(0)});
  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;
  state_t state_q;
  spr_t act_q [NUM_SPRITES];
  spr_t shd_q [NUM_SPRITES];
  spr_t cur [NUM_SPRITES];
  spr_t wr_sp;
  logic fb, v_d, bl_d;
  logic signed [COORD_W:0] dx_d [NUM_SPRITES];
  logic signed [COORD_W:0] dy_d [NUM_SPRITES];
  logic [COORD_W-1:0] adx_d [NUM_SPRITES];
  logic [COORD_W-1:0] ady_d [NUM_SPRITES];
  logic [COORD_W-1:0] adx1_q [NUM_SPRITES];
  logic [COORD_W-1:0] ady1_q [NUM_SPRITES];
  logic [RADIUS_W-1:0] r1_q [NUM_SPRITES];
  logic [1:0] sh1_q [NUM_SPRITES];
  logic [COLOR_W-1:0] c1_q [NUM_SPRITES];
  logic [COLOR_W-1:0] c2_q [NUM_SPRITES];
  logic v1_q, fb1_q, bl1_q, v2_q, fb2_q;
  logic [NUM_SPRITES-1:0] hit_d, hit2_q;
  logic [COLOR_W-1:0] col_d;
  logic coll_d;
  assign fb = pix_valid && next_x == '0 && next_y == '0;
  assign wr_sp = {wr_x, wr_y, wr_radius, wr_shape, wr_color};
  assign v_d = pix_valid && start && state_q != IDLE;
  // the frame-boundary pixel itself belongs to the new frame, so it is not blanked
  assign bl_d = state_q == CLEAR && !fb;
  // run control: any cycle without start returns to IDLE
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else if (!start) state_q <= IDLE;
    else if (state_q == IDLE) state_q <= CLEAR;
    else if (state_q == CLEAR && fb) state_q <= RUN;
  // shadow writes and frame-boundary commit; the copy sees the pre-write shadow
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        act_q[i] <= HIDDEN;
        shd_q[i] <= HIDDEN;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (wr_en && int'(wr_idx) == i) shd_q[i] <= wr_sp;
        if (fb) act_q[i] <= shd_q[i];
      end
    end
  // stage 1 math: the boundary pixel reads the shadow so it already uses the new table
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      cur[i] = fb ? shd_q[i] : act_q[i];
      dx_d[i] = $signed({1'b0, next_x}) - $signed({1'b0, cur[i].x});
      dy_d[i] = $signed({1'b0, next_y}) - $signed({1'b0, cur[i].y});
      adx_d[i] = dx_d[i][COORD_W] ? COORD_W'(-dx_d[i]) : COORD_W'(dx_d[i]);
      ady_d[i] = dy_d[i][COORD_W] ? COORD_W'(-dy_d[i]) : COORD_W'(dy_d[i]);
    end
  end
  // stage 1 registers: distances plus the sprite attributes they were measured against
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1_q <= 1'b0;
      fb1_q <= 1'b0;
      bl1_q <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        adx1_q[i] <= '0;
        ady1_q[i] <= '0;
        r1_q[i] <= '0;
        sh1_q[i] <= 2'd3;
        c1_q[i] <= '0;
      end
    end else begin
      v1_q <= v_d;
      fb1_q <= fb;
      bl1_q <= bl_d;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        adx1_q[i] <= adx_d[i];
        ady1_q[i] <= ady_d[i];
        r1_q[i] <= cur[i].r;
        sh1_q[i] <= cur[i].shape;
        c1_q[i] <= cur[i].color;
      end
    end
  // stage 2 hit test per shape; disc uses full-width squares
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_SPRITES; i++)
      hit_d[i] = sh1_q[i] == 2'd0 ? (adx1_q[i] <= COORD_W'(r1_q[i]) && ady1_q[i] <= COORD_W'(r1_q[i])) :
                 sh1_q[i] == 2'd1 ? ((adx1_q[i] >= ady1_q[i] ? adx1_q[i] : ady1_q[i]) == COORD_W'(r1_q[i])) :
                 sh1_q[i] == 2'd2 ? (SW'(adx1_q[i]) * SW'(adx1_q[i]) + SW'(ady1_q[i]) * SW'(ady1_q[i]) <= SW'(r1_q[i]) * SW'(r1_q[i])) :
                 1'b0;
  end
  // stage 2 registers; blanked pixels carry an empty hit vector
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v2_q <= 1'b0;
      fb2_q <= 1'b0;
      hit2_q <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) c2_q[i] <= '0;
    end else begin
      v2_q <= v1_q && start;
      fb2_q <= fb1_q;
      hit2_q <= bl1_q ? '0 : hit_d;
      for (int i = 0; i < NUM_SPRITES; i++) c2_q[i] <= c1_q[i];
    end
  // stage 3 priority: lowest-index hit wins
  always_comb begin
    col_d = BG_COLOR;
    for (int i = NUM_SPRITES-1; i >= 0; i--) col_d = hit2_q[i] ? c2_q[i] : col_d;
    coll_d = hit2_q[0] && |(hit2_q >> 1);
  end
  // stage 3 outputs; bubbles hold colour, a new frame clears collide unless it collides itself
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      color_out <= BG_COLOR;
      color_vld <= 1'b0;
      hit_mask <= '0;
      collide <= 1'b0;
    end else if (!start) begin
      color_out <= BG_COLOR;
      color_vld <= 1'b0;
      hit_mask <= '0;
      collide <= 1'b0;
    end else begin
      color_vld <= v2_q;
      if (v2_q) begin
        color_out <= col_d;
        hit_mask <= hit2_q;
        collide <= coll_d || (collide && !fb2_q);
      end
    end
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: scoreboard bench for sprite_compositor with directed pixel vectors
module tb_sprite_compositor;
  localparam int N = 6;
  logic clk = 0, rst = 1, start = 0, pix_valid = 0, wr_en = 0;
  logic [9:0] next_x = 0, next_y = 0, wr_x = 0, wr_y = 0;
  logic [2:0] wr_idx = 0;
  logic [6:0] wr_radius = 0;
  logic [1:0] wr_shape = 3;
  logic [7:0] wr_color = 0;
  logic [7:0] color_out;
  logic color_vld;
  logic [N-1:0] hit_mask;
  logic collide;
  typedef struct {
    logic [7:0] col;
    logic [N-1:0] mask;
    int cyc;
  } exp_t;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0, n_pix = 0;

  sprite_compositor #(.NUM_SPRITES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
    .next_x(next_x), .next_y(next_y), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_x(wr_x), .wr_y(wr_y), .wr_radius(wr_radius), .wr_shape(wr_shape),
    .wr_color(wr_color), .color_out(color_out), .color_vld(color_vld),
    .hit_mask(hit_mask), .collide(collide)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && color_vld) begin
      n_chk++;
      n_pix++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_vld: color_vld=1 with no pixel pending at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        if (color_out !== e.col || hit_mask !== e.mask || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL pixel%0d: color %0h mask %b cycle %0d, expected color %0h mask %b cycle %0d",
                   n_pix, color_out, hit_mask, cyc, e.col, e.mask, e.cyc);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_wr(input int idx, input int x, input int y, input int r, input int sh, input int col);
    wr_en = 1;
    wr_idx = 3'(idx);
    wr_x = 10'(x);
    wr_y = 10'(y);
    wr_radius = 7'(r);
    wr_shape = 2'(sh);
    wr_color = 8'(col);
  endtask

  task automatic wr(input int idx, input int x, input int y, input int r, input int sh, input int col);
    set_wr(idx, x, y, r, sh, col);
    tick;
    wr_en = 0;
  endtask

  task automatic pix(input int x, input int y, input int col, input int mask);
    exp_t e;
    e.col = 8'(col);
    e.mask = N'(mask);
    e.cyc = cyc + 3;
    q.push_back(e);
    pix_valid = 1;
    next_x = 10'(x);
    next_y = 10'(y);
    tick;
    pix_valid = 0;
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick;
    chk("drain_pending", 32'(q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick;
    chk("rst_color", 32'(color_out), 0);
    chk("rst_vld", 32'(color_vld), 0);
    chk("rst_mask", 32'(hit_mask), 0);
    chk("rst_collide", 32'(collide), 0);
    rst = 0;
    start = 1;
    tick;
    // clear phase, then the first committed frame
    wr(0, 100, 100, 10, 0, 'hE0);
    pix(100, 100, 0, 0);
    pix(95, 105, 0, 0);
    pix(0, 0, 0, 0);
    pix(90, 90, 'hE0, 1);
    pix(110, 110, 'hE0, 1);
    tick;
    pix(89, 100, 0, 0);
    pix(111, 100, 0, 0);
    repeat (2) tick;
    pix(100, 89, 0, 0);
    pix(100, 111, 0, 0);
    pix(100, 100, 'hE0, 1);
    drain;
    // disc
    wr(0, 50, 50, 5, 2, 'h3F);
    pix(0, 0, 0, 0);
    pix(53, 54, 'h3F, 1);
    pix(54, 54, 0, 0);
    pix(50, 45, 'h3F, 1);
    pix(45, 50, 'h3F, 1);
    pix(46, 46, 0, 0);
    drain;
    // ring over box, priority and collide
    wr(0, 20, 20, 4, 1, 'h03);
    wr(1, 20, 20, 8, 0, 'h1C);
    pix(0, 0, 0, 0);
    drain;
    chk("collide_before_overlap", 32'(collide), 0);
    pix(24, 20, 'h03, 3);
    pix(21, 20, 'h1C, 2);
    pix(20, 20, 'h1C, 2);
    pix(28, 28, 'h1C, 2);
    pix(29, 20, 0, 0);
    pix(24, 24, 'h03, 3);
    drain;
    chk("collide_set", 32'(collide), 1);
    // mid-frame write and write coincident with the frame boundary
    wr(2, 200, 200, 3, 0, 'hAA);
    pix(200, 200, 0, 0);
    drain;
    chk("collide_sticky", 32'(collide), 1);
    set_wr(3, 300, 300, 3, 0, 'h55);
    pix(0, 0, 0, 0);
    wr_en = 0;
    pix(200, 200, 'hAA, 4);
    pix(300, 300, 0, 0);
    drain;
    chk("collide_cleared_fb", 32'(collide), 0);
    pix(0, 0, 0, 0);
    pix(300, 300, 'h55, 8);
    drain;
    // edge clipping without wrap, out-of-range slots
    wr(4, 2, 2, 5, 0, 'h77);
    wr(6, 400, 400, 5, 0, 'h99);
    wr(7, 400, 400, 5, 0, 'h99);
    pix(0, 0, 'h77, 16);
    pix(639, 0, 0, 0);
    pix(1021, 2, 0, 0);
    pix(7, 7, 'h77, 16);
    pix(8, 2, 0, 0);
    pix(400, 400, 0, 0);
    drain;
    // start dropped mid-frame, then reasserted
    wr(4, 2, 2, 5, 3, 'h77);
    pix(24, 20, 'h03, 3);
    drain;
    chk("collide_pre_drop", 32'(collide), 1);
    pix_valid = 1;
    next_x = 7;
    next_y = 7;
    tick;
    start = 0;
    tick;
    chk("drop_vld", 32'(color_vld), 0);
    chk("drop_collide", 32'(collide), 0);
    chk("drop_color", 32'(color_out), 0);
    chk("drop_mask", 32'(hit_mask), 0);
    repeat (4) tick;
    pix_valid = 0;
    start = 1;
    tick;
    pix(24, 20, 0, 0);
    pix(21, 20, 0, 0);
    pix(0, 0, 0, 0);
    pix(24, 20, 'h03, 3);
    pix(7, 7, 0, 0);
    drain;
    repeat (3) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
